psram_dev_resp: RTL and testbench



---
 rtl/psram_dev_resp.sv | 164 ++++++++++++++++
 tb/tb_psram_dev_resp.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/psram_dev_resp.sv
`default_nettype none
// psram_dev_resp: device-side responder for the octal-DDR PSRAM link, oversampling sck/ce/io/dqs on clk_i.
// Rev 1.0 - linear-burst read/write from an internal byte array, global reset with busy window.
module psram_dev_resp #(
  parameter int         DEPTH   = 256,
  parameter logic [7:0] RCMD    = 8'h20,
  parameter logic [7:0] WCMD    = 8'hA0,
  parameter logic [7:0] RSTCMD  = 8'hFF,
  parameter int         RLC     = 5,
  parameter int         WLC     = 5,
  parameter int         RST_CYC = 16
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       psram_sck_i,
  input  logic       psram_ce_i,
  input  logic [7:0] psram_io_in_i,
  output logic [7:0] psram_io_out_o,
  output logic [7:0] psram_io_en_o,
  input  logic       psram_dqs_in_i,
  output logic       psram_dqs_out_o,
  output logic       psram_dqs_en_o,
  output logic       busy_o,
  output logic       cmd_err_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(RST_CYC + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_INST   = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_LATN   = 3'd3;
  localparam logic [2:0] S_WDATA  = 3'd4;
  localparam logic [2:0] S_RDATA  = 3'd5;
  localparam logic [2:0] S_IGNORE = 3'd6;
  localparam logic [2:0] S_BUSY   = 3'd7;

  logic [2:0]    state, state_nx;
  logic          sck_q, ce_q;
  logic [1:0]    cnt;
  logic [7:0]    inst0;
  logic [31:0]   addr;
  logic [7:0]    lat_cnt;
  logic          is_read, rst_flag;
  logic [BW-1:0] busy_cnt;
  logic [7:0]    mem [DEPTH];

  logic          rise, fall, act;
  logic          inst_rd, inst_wr, inst_rst, inst_ok;
  logic [AW-1:0] idx;

  assign rise     = psram_sck_i & ~sck_q;
  assign fall     = ~psram_sck_i & sck_q;
  // ce deasserted in the same cycle as an edge discards that edge
  assign act      = (rise | fall) & ~psram_ce_i;
  assign inst_rd  = (inst0 == psram_io_in_i) && (psram_io_in_i == RCMD);
  assign inst_wr  = (inst0 == psram_io_in_i) && (psram_io_in_i == WCMD);
  assign inst_rst = (inst0 == psram_io_in_i) && (psram_io_in_i == RSTCMD);
  assign inst_ok  = inst_rd | inst_wr | inst_rst;
  assign idx      = addr[AW-1:0];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (state == S_BUSY) begin
      if (busy_cnt == '0) state_nx = S_IDLE;
    end else if (psram_ce_i) begin
      state_nx = (state == S_IGNORE && rst_flag) ? S_BUSY : S_IDLE;
    end else begin
      case (state)
        // a fresh ce fall is required, so a select held low through BUSY is never decoded
        S_IDLE: if (ce_q) state_nx = S_INST;
        S_INST: if (act && cnt[0]) state_nx = (inst_ok && !inst_rst) ? S_ADDR : S_IGNORE;
        S_ADDR: if (act && cnt == 2'd3) state_nx = S_LATN;
        S_LATN: if (lat_cnt == 8'd0) state_nx = is_read ? S_RDATA : S_WDATA;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o         = (state == S_BUSY);
    psram_io_en_o  = 8'h00;
    psram_dqs_en_o = 1'b0;
    if (!psram_ce_i && state == S_RDATA) begin
      psram_io_en_o  = 8'hFF;
      psram_dqs_en_o = 1'b1;
    end else if (!psram_ce_i && state == S_LATN && is_read) begin
      psram_dqs_en_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sck_q           <= 1'b0;
      ce_q            <= 1'b1;
      cnt             <= 2'd0;
      inst0           <= 8'h00;
      addr            <= 32'h0;
      lat_cnt         <= 8'd0;
      is_read         <= 1'b0;
      rst_flag        <= 1'b0;
      busy_cnt        <= '0;
      cmd_err_o       <= 1'b0;
      psram_io_out_o  <= 8'h00;
      psram_dqs_out_o <= 1'b0;
    end else begin
      sck_q     <= psram_sck_i;
      ce_q      <= psram_ce_i;
      cmd_err_o <= 1'b0;
      case (state)
        S_IDLE: begin
          cnt      <= 2'd0;
          rst_flag <= 1'b0;
        end
        S_INST: if (act) begin
          if (!cnt[0]) begin
            inst0 <= psram_io_in_i;
            cnt   <= 2'd1;
          end else begin
            cnt       <= 2'd0;
            is_read   <= inst_rd;
            rst_flag  <= inst_rst;
            cmd_err_o <= ~inst_ok;
          end
        end
        S_ADDR: if (act) begin
          addr <= {addr[23:0], psram_io_in_i};
          cnt  <= cnt + 2'd1;
          if (cnt == 2'd3) lat_cnt <= is_read ? 8'(RLC) : 8'(WLC);
        end
        S_LATN: if (act && rise && lat_cnt != 8'd0) lat_cnt <= lat_cnt - 8'd1;
        S_WDATA: if (act) addr <= addr + 32'd1;
        S_RDATA: if (act) begin
          psram_io_out_o  <= mem[idx];
          psram_dqs_out_o <= ~psram_dqs_out_o;
          addr            <= addr + 32'd1;
        end
        S_IGNORE: if (psram_ce_i && rst_flag) begin
          busy_cnt <= BW'(RST_CYC - 1);
          rst_flag <= 1'b0;
        end
        S_BUSY: if (busy_cnt != '0) busy_cnt <= busy_cnt - 1'b1;
        default: ;
      endcase
      // dqs starts low so the first read byte drives it high
      if (state_nx != S_RDATA) begin
        psram_io_out_o  <= 8'h00;
        psram_dqs_out_o <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (state == S_WDATA && act && !psram_dqs_in_i) mem[idx] <= psram_io_in_i;
  end

endmodule
`default_nettype wire

// File: tb/tb_psram_dev_resp.sv
`default_nettype none
// tb_psram_dev_resp: directed self-checking bench for psram_dev_resp.
module tb_psram_dev_resp;

  localparam logic [7:0] RCMD   = 8'h20;
  localparam logic [7:0] WCMD   = 8'hA0;
  localparam logic [7:0] RSTCMD = 8'hFF;

  logic       clk_i   = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       sck     = 1'b0;
  logic       ce      = 1'b1;
  logic       dqs_in  = 1'b0;
  logic [7:0] io_in   = 8'h00;
  logic [7:0] io_out, io_en;
  logic       dqs_out, dqs_en, busy_o, cmd_err_o;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  int busy_cycles = 0;

  psram_dev_resp dut (
    .clk_i          (clk_i),
    .rst_n_i        (rst_n_i),
    .psram_sck_i    (sck),
    .psram_ce_i     (ce),
    .psram_io_in_i  (io_in),
    .psram_io_out_o (io_out),
    .psram_io_en_o  (io_en),
    .psram_dqs_in_i (dqs_in),
    .psram_dqs_out_o(dqs_out),
    .psram_dqs_en_o (dqs_en),
    .busy_o         (busy_o),
    .cmd_err_o      (cmd_err_o)
  );

  always #5 clk_i = ~clk_i;

  always @(negedge clk_i) begin
    if (cmd_err_o) err_pulses++;
    if (busy_o) busy_cycles++;
  end

  // one DDR byte per sck edge, each sck phase is 4 clk_i cycles
  task automatic edge_byte(input logic [7:0] d, input logic m);
    @(negedge clk_i);
    io_in = d; dqs_in = m; sck = ~sck;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic begin_cmd();
    @(negedge clk_i);
    ce = 1'b0; sck = 1'b0;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic end_cmd();
    @(negedge clk_i);
    ce = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk_i);
  endtask

  // instruction, address and the first 8 of 9 latency edges (5 rises)
  task automatic hdr(input logic [7:0] i0, input logic [7:0] i1, input logic [31:0] a);
    edge_byte(i0, 1'b0);
    edge_byte(i1, 1'b0);
    for (int i = 0; i < 4; i++) edge_byte(a[31-8*i -: 8], 1'b0);
    for (int i = 0; i < 8; i++) edge_byte(8'h00, 1'b0);
  endtask

  task automatic write_burst(input logic [7:0] i0, input logic [7:0] i1, input logic [31:0] a,
                             input logic [31:0] d, input logic [3:0] m, output logic drv);
    drv = 1'b0;
    begin_cmd();
    hdr(i0, i1, a);
    edge_byte(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      edge_byte(d[31-8*i -: 8], m[3-i]);
      drv = drv | (|io_en) | dqs_en;
    end
    end_cmd();
  endtask

  task automatic read_burst(input logic [31:0] a, output logic [31:0] d, output logic [3:0] dq,
                            output logic [31:0] en, output logic lat_dqs_en,
                            output logic lat_dqs_out, output logic [7:0] lat_io_en);
    begin_cmd();
    hdr(RCMD, RCMD, a);
    lat_dqs_en = dqs_en; lat_dqs_out = dqs_out; lat_io_en = io_en;
    edge_byte(8'h00, 1'b0);
    for (int i = 0; i < 4; i++) begin
      edge_byte(8'h00, 1'b0);
      d[31-8*i -: 8]  = io_out;
      dq[3-i]         = dqs_out;
      en[31-8*i -: 8] = io_en;
    end
    end_cmd();
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_i);
    total++; if (io_out !== 8'h00) begin bad++; $display("FAIL reset_io_out: got %h want 00", io_out); end
    total++; if (io_en !== 8'h00) begin bad++; $display("FAIL reset_io_en: got %h want 00", io_en); end
    total++; if ({dqs_out, dqs_en, busy_o, cmd_err_o} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {dqs_out, dqs_en, busy_o, cmd_err_o});
    end
    rst_n_i = 1'b1;
    repeat (2) @(negedge clk_i);
  endtask

  task automatic test_write_read();
    logic drv, lde, ldo;
    logic [31:0] d, en;
    logic [3:0] dq;
    logic [7:0] lie;
    write_burst(WCMD, WCMD, 32'h10, 32'h11223344, 4'b0000, drv);
    total++; if (drv !== 1'b0) begin bad++; $display("FAIL wr_no_drive: got %b want 0", drv); end
    read_burst(32'h10, d, dq, en, lde, ldo, lie);
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL rd_data: got %h want 11223344", d); end
    total++; if (dq !== 4'b1010) begin bad++; $display("FAIL rd_dqs: got %b want 1010", dq); end
    total++; if (en !== 32'hFFFFFFFF) begin bad++; $display("FAIL rd_io_en: got %h want ffffffff", en); end
    total++; if ({lde, ldo, lie} !== {1'b1, 1'b0, 8'h00}) begin
      bad++; $display("FAIL latn_drive: got dqs_en=%b dqs=%b io_en=%h want 1 0 00", lde, ldo, lie);
    end
    total++; if ({io_en, dqs_en} !== 9'h0) begin bad++; $display("FAIL idle_en: got %h %b want 00 0", io_en, dqs_en); end
  endtask

  task automatic test_mask();
    logic drv, lde, ldo;
    logic [31:0] d, en;
    logic [3:0] dq;
    logic [7:0] lie;
    write_burst(WCMD, WCMD, 32'h20, 32'h00000000, 4'b0000, drv);
    write_burst(WCMD, WCMD, 32'h20, 32'hAABBCCDD, 4'b0101, drv);
    read_burst(32'h20, d, dq, en, lde, ldo, lie);
    total++; if (d !== 32'hAA00CC00) begin bad++; $display("FAIL mask_data: got %h want aa00cc00", d); end
  endtask

  task automatic test_wrap();
    logic drv, lde, ldo;
    logic [31:0] d, en;
    logic [3:0] dq;
    logic [7:0] lie;
    write_burst(WCMD, WCMD, 32'hFE, 32'h5AA53CC3, 4'b0000, drv);
    read_burst(32'hFE, d, dq, en, lde, ldo, lie);
    total++; if (d !== 32'h5AA53CC3) begin bad++; $display("FAIL wrap_fe: got %h want 5aa53cc3", d); end
    read_burst(32'h00, d, dq, en, lde, ldo, lie);
    total++; if (d[31:16] !== 16'h3CC3) begin bad++; $display("FAIL wrap_00: got %h want 3cc3", d[31:16]); end
  endtask

  task automatic test_bad_inst();
    logic drv, lde, ldo;
    logic [31:0] d, en;
    logic [3:0] dq;
    logic [7:0] lie;
    err_pulses = 0;
    write_burst(RCMD, WCMD, 32'h10, 32'hEEEEEEEE, 4'b0000, drv);
    total++; if (err_pulses !== 1) begin bad++; $display("FAIL err_mismatch: got %0d pulses want 1", err_pulses); end
    total++; if (drv !== 1'b0) begin bad++; $display("FAIL err_mismatch_drive: got %b want 0", drv); end
    write_burst(8'h55, 8'h55, 32'h10, 32'hEEEEEEEE, 4'b0000, drv);
    total++; if (err_pulses !== 2) begin bad++; $display("FAIL err_unknown: got %0d pulses want 2", err_pulses); end
    total++; if (drv !== 1'b0) begin bad++; $display("FAIL err_unknown_drive: got %b want 0", drv); end
    read_burst(32'h10, d, dq, en, lde, ldo, lie);
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL err_no_write: got %h want 11223344", d); end
    total++; if (err_pulses !== 2) begin bad++; $display("FAIL err_valid_read: got %0d pulses want 2", err_pulses); end
  endtask

  task automatic test_abort();
    logic lde, ldo;
    logic [31:0] d, en;
    logic [3:0] dq;
    logic [7:0] lie;
    begin_cmd();
    edge_byte(RCMD, 1'b0); edge_byte(RCMD, 1'b0);
    edge_byte(8'h00, 1'b0); edge_byte(8'h00, 1'b0);
    end_cmd();
    total++; if ({io_en, dqs_en} !== 9'h0) begin bad++; $display("FAIL abort_addr_en: got %h %b want 00 0", io_en, dqs_en); end
    // abort in the middle of a read burst: enables must drop with ce
    begin_cmd();
    hdr(RCMD, RCMD, 32'h10);
    edge_byte(8'h00, 1'b0); edge_byte(8'h00, 1'b0); edge_byte(8'h00, 1'b0);
    total++; if (io_en !== 8'hFF) begin bad++; $display("FAIL abort_pre_en: got %h want ff", io_en); end
    @(negedge clk_i);
    ce = 1'b1; sck = 1'b0;
    #1;
    total++; if ({io_en, dqs_en} !== 9'h0) begin bad++; $display("FAIL abort_rd_en: got %h %b want 00 0", io_en, dqs_en); end
    repeat (3) @(negedge clk_i);
    read_burst(32'h10, d, dq, en, lde, ldo, lie);
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL abort_reread: got %h want 11223344", d); end
    total++; if (dq !== 4'b1010) begin bad++; $display("FAIL abort_reread_dqs: got %b want 1010", dq); end
  endtask

  task automatic test_global_reset();
    logic drv, lde, ldo;
    logic [31:0] d, en;
    logic [3:0] dq;
    logic [7:0] lie;
    err_pulses = 0;
    begin_cmd();
    edge_byte(RSTCMD, 1'b0); edge_byte(RSTCMD, 1'b0);
    busy_cycles = 0;
    @(negedge clk_i);
    ce = 1'b1; sck = 1'b0;
    repeat (3) @(negedge clk_i);
    total++; if (busy_o !== 1'b1) begin bad++; $display("FAIL gr_busy_on: got %b want 1", busy_o); end
    write_burst(WCMD, WCMD, 32'h10, 32'h99999999, 4'b0000, drv);
    total++; if (busy_cycles !== 16) begin bad++; $display("FAIL gr_busy_len: got %0d cycles want 16", busy_cycles); end
    total++; if (busy_o !== 1'b0) begin bad++; $display("FAIL gr_busy_off: got %b want 0", busy_o); end
    total++; if (err_pulses !== 0) begin bad++; $display("FAIL gr_no_err: got %0d pulses want 0", err_pulses); end
    read_burst(32'h10, d, dq, en, lde, ldo, lie);
    total++; if (d !== 32'h11223344) begin bad++; $display("FAIL gr_busy_ignored: got %h want 11223344", d); end
    write_burst(WCMD, WCMD, 32'h40, 32'h55667788, 4'b0000, drv);
    read_burst(32'h40, d, dq, en, lde, ldo, lie);
    total++; if (d !== 32'h55667788) begin bad++; $display("FAIL gr_after_busy: got %h want 55667788", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_wrap();
    test_bad_inst();
    test_abort();
    test_global_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
